// File: rtl/arbitro_wrr_vc_pkg.sv
// Shared types and defaults for the weighted round-robin VC scheduler.
package arbitro_wrr_vc_pkg;

  localparam int unsigned DATA_W_DEF   = 6;
  localparam int unsigned WEIGHT_W_DEF = 3;
  localparam int unsigned CNT_W        = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_VC0 = 2'd1,
    SERVE_VC1 = 2'd2
  } state_e;

  // Destination-select bit inside a data word.
  function automatic int unsigned dest_bit(input int unsigned data_w);
    return data_w - 2;
  endfunction

endpackage

// File: rtl/arbitro_wrr_vc_contador_creditos.sv
// Per-VC credit counter: loads from weight (0 treated as 1), decrements per pop.
module arbitro_wrr_vc_contador_creditos
  import arbitro_wrr_vc_pkg::*;
#(
  parameter int unsigned WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                load_i,
  input  logic                dec_i,
  input  logic [WEIGHT_W-1:0] weight_i,
  output logic [WEIGHT_W-1:0] credit_o,
  output logic                zero_o,
  output logic                last_o
);

  logic [WEIGHT_W-1:0] credit_q, credit_d;

  // Load wins over decrement so a same-VC reload restarts the turn cleanly.
  always_comb begin
    credit_d = credit_q;
    if (load_i) begin
      credit_d = (weight_i == '0) ? WEIGHT_W'(1) : weight_i;
    end else if (dec_i && (credit_q != '0)) begin
      credit_d = credit_q - WEIGHT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign credit_o = credit_q;
  assign zero_o   = (credit_q == '0);
  assign last_o   = (credit_q == WEIGHT_W'(1));

endmodule

// File: rtl/arbitro_wrr_vc.sv
// Weighted round-robin pop scheduler between VC0/VC1 and D0/D1 push stage.
// Optional per-VC forwarded-word counters under ARBITRO_STATS_EN.
module arbitro_wrr_vc
  import arbitro_wrr_vc_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                enable,
  input  logic [DATA_W-1:0]   VC0_data,
  input  logic [DATA_W-1:0]   VC1_data,
  input  logic                VC0_empty,
  input  logic                VC1_empty,
  input  logic                almost_full_D0,
  input  logic                almost_full_D1,
  input  logic [WEIGHT_W-1:0] weight_VC0,
  input  logic [WEIGHT_W-1:0] weight_VC1,
  output logic                VC0_pop,
  output logic                VC1_pop,
  output logic                D0_push,
  output logic                D1_push,
  output logic [DATA_W-1:0]   D0_data,
  output logic [DATA_W-1:0]   D1_data,
  output logic                idle,
  output logic [CNT_W-1:0]    count_VC0,
  output logic [CNT_W-1:0]    count_VC1
);

  localparam int unsigned DBIT = dest_bit(DATA_W);

  state_e              state_q, state_d;
  logic                load0_c, load1_c, dec0_c, dec1_c;
  logic [WEIGHT_W-1:0] cred0, cred1;
  logic                zero0, zero1, last0, last1;
  logic                blocked_c, pop0_c, pop1_c;
  logic                valid_q, valid_d, src_q, src_d;
  logic                push0_q, push0_d, push1_q, push1_d;
  logic [DATA_W-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic [DATA_W-1:0]   sel_data_c;
  logic                idle_q, idle_d;

  arbitro_wrr_vc_contador_creditos #(.WEIGHT_W(WEIGHT_W)) u_cred_vc0 (
    .clk      (clk),
    .reset_L  (reset_L),
    .load_i   (load0_c),
    .dec_i    (dec0_c),
    .weight_i (weight_VC0),
    .credit_o (cred0),
    .zero_o   (zero0),
    .last_o   (last0)
  );

  arbitro_wrr_vc_contador_creditos #(.WEIGHT_W(WEIGHT_W)) u_cred_vc1 (
    .clk      (clk),
    .reset_L  (reset_L),
    .load_i   (load1_c),
    .dec_i    (dec1_c),
    .weight_i (weight_VC1),
    .credit_o (cred1),
    .zero_o   (zero1),
    .last_o   (last1)
  );

  // Destination is unknown until the word is read, so either almost-full stalls.
  always_comb begin
    state_d   = state_q;
    load0_c   = 1'b0;
    load1_c   = 1'b0;
    dec0_c    = 1'b0;
    dec1_c    = 1'b0;
    pop0_c    = 1'b0;
    pop1_c    = 1'b0;
    blocked_c = almost_full_D0 | almost_full_D1 | ~enable;
    case (state_q)
      IDLE: begin
        if (enable && !VC0_empty) begin
          state_d = SERVE_VC0;
          load0_c = 1'b1;
        end else if (enable && !VC1_empty) begin
          state_d = SERVE_VC1;
          load1_c = 1'b1;
        end
      end
      SERVE_VC0: begin
        if (!blocked_c) begin
          pop0_c = !VC0_empty && !zero0;
          dec0_c = pop0_c;
          if ((pop0_c && last0) || zero0 || VC0_empty) begin
            if (!VC1_empty) begin
              state_d = SERVE_VC1;
              load1_c = 1'b1;
            end else if (!VC0_empty) begin
              load0_c = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      SERVE_VC1: begin
        if (!blocked_c) begin
          pop1_c = !VC1_empty && !zero1;
          dec1_c = pop1_c;
          if ((pop1_c && last1) || zero1 || VC1_empty) begin
            if (!VC0_empty) begin
              state_d = SERVE_VC0;
              load0_c = 1'b1;
            end else if (!VC1_empty) begin
              load1_c = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!reset_L) begin
      pop0_c = 1'b0;
      pop1_c = 1'b0;
    end
  end

  // Two-stage datapath: pop -> read-data stage -> registered push.
  always_comb begin
    valid_d    = pop0_c | pop1_c;
    src_d      = pop1_c;
    sel_data_c = src_q ? VC1_data : VC0_data;
    push0_d    = valid_q && !sel_data_c[DBIT];
    push1_d    = valid_q &&  sel_data_c[DBIT];
    data0_d    = push0_d ? sel_data_c : data0_q;
    data1_d    = push1_d ? sel_data_c : data1_q;
    idle_d     = (state_d == IDLE) && !valid_d && !push0_d && !push1_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      push0_q <= 1'b0;
      push1_q <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      push0_q <= push0_d;
      push1_q <= push1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      idle_q  <= idle_d;
    end
  end

  assign VC0_pop = pop0_c;
  assign VC1_pop = pop1_c;
  assign D0_push = push0_q;
  assign D1_push = push1_q;
  assign D0_data = data0_q;
  assign D1_data = data1_q;
  assign idle    = idle_q;

`ifdef ARBITRO_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating per-source counters, bumped in the same edge that raises the push.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if ((push0_d || push1_d) && !src_q && (cnt0_q != '1)) begin
      cnt0_d = cnt0_q + CNT_W'(1);
    end
    if ((push0_d || push1_d) && src_q && (cnt1_q != '1)) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign count_VC0 = cnt0_q;
  assign count_VC1 = cnt1_q;
`else
  assign count_VC0 = '0;
  assign count_VC1 = '0;
`endif

endmodule

// File: tb/tb_arbitro_wrr_vc.sv
// Bench for arbitro_wrr_vc: FIFO/scheduler reference model plus directed tables.
module tb_arbitro_wrr_vc;

  localparam int DW = 6;
  localparam int WW = 3;

  logic          clk;
  logic          reset_L;
  logic          enable;
  logic [DW-1:0] VC0_data, VC1_data;
  logic          VC0_empty, VC1_empty;
  logic          almost_full_D0, almost_full_D1;
  logic [WW-1:0] weight_VC0, weight_VC1;
  logic          VC0_pop, VC1_pop;
  logic          D0_push, D1_push;
  logic [DW-1:0] D0_data, D1_data;
  logic          idle;
  logic [7:0]    count_VC0, count_VC1;

  arbitro_wrr_vc #(.DATA_W(DW), .WEIGHT_W(WW)) dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .enable         (enable),
    .VC0_data       (VC0_data),
    .VC1_data       (VC1_data),
    .VC0_empty      (VC0_empty),
    .VC1_empty      (VC1_empty),
    .almost_full_D0 (almost_full_D0),
    .almost_full_D1 (almost_full_D1),
    .weight_VC0     (weight_VC0),
    .weight_VC1     (weight_VC1),
    .VC0_pop        (VC0_pop),
    .VC1_pop        (VC1_pop),
    .D0_push        (D0_push),
    .D1_push        (D1_push),
    .D0_data        (D0_data),
    .D1_data        (D1_data),
    .idle           (idle),
    .count_VC0      (count_VC0),
    .count_VC1      (count_VC1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            c;
    logic [DW-1:0] w;
    bit            src;
  } push_t;

  typedef struct {
    bit            src;
    logic [DW-1:0] w;
    bit            exp_p0;
    bit            exp_p1;
    int            exp_lat;
  } vec_t;

  int            checks, errors, cyc;
  logic [DW-1:0] q0[$], q1[$];
  push_t         pushq[$];
  int            pop_log[$], pop_cyc[$];
  int            m_turn, m_cred, m_cnt0, m_cnt1;
  logic [DW-1:0] m_d0, m_d1;
  bit            obs_p0, obs_p1;
  logic [DW-1:0] obs_d0, obs_d1;
  int            last_push_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int wt(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  // One clock: check registered outputs and pop strobes, then advance FIFO model.
  task automatic tick();
    bit            e[2];
    int            wv[2];
    bit            pp[2];
    bit            blk, ep0, ep1, exp_idle;
    logic [DW-1:0] pw;
    int            x, o;
    push_t         pt;
    VC0_empty = (q0.size() == 0);
    VC1_empty = (q1.size() == 0);
    @(negedge clk);
    exp_idle = (m_turn == 0) && (pushq.size() == 0);
    ep0 = 1'b0;
    ep1 = 1'b0;
    if (pushq.size() != 0 && pushq[0].c == cyc) begin
      pt = pushq.pop_front();
      if (pt.w[DW-2]) begin ep1 = 1'b1; m_d1 = pt.w; end
      else begin ep0 = 1'b1; m_d0 = pt.w; end
`ifdef ARBITRO_STATS_EN
      if (pt.src) begin if (m_cnt1 < 255) m_cnt1++; end
      else if (m_cnt0 < 255) m_cnt0++;
`endif
    end
    obs_p0 = D0_push;
    obs_p1 = D1_push;
    obs_d0 = D0_data;
    obs_d1 = D1_data;
    if (D0_push || D1_push) last_push_cyc = cyc;
    chk("D0_push", 32'(D0_push), 32'(ep0));
    chk("D1_push", 32'(D1_push), 32'(ep1));
    chk("D0_data", 32'(D0_data), 32'(m_d0));
    chk("D1_data", 32'(D1_data), 32'(m_d1));
    chk("idle", 32'(idle), 32'(exp_idle));
    chk("count_VC0", 32'(count_VC0), 32'(m_cnt0));
    chk("count_VC1", 32'(count_VC1), 32'(m_cnt1));

    pp[0] = 1'b0;
    pp[1] = 1'b0;
    e[0]  = VC0_empty;
    e[1]  = VC1_empty;
    wv[0] = int'(weight_VC0);
    wv[1] = int'(weight_VC1);
    blk   = almost_full_D0 | almost_full_D1 | !enable;
    if (reset_L) begin
      if (m_turn == 0) begin
        if (enable && !e[0]) begin m_turn = 1; m_cred = wt(wv[0]); end
        else if (enable && !e[1]) begin m_turn = 2; m_cred = wt(wv[1]); end
      end else if (!blk) begin
        x = m_turn - 1;
        o = 1 - x;
        if (!e[x] && m_cred > 0) begin pp[x] = 1'b1; m_cred--; end
        if ((pp[x] && m_cred == 0) || e[x]) begin
          if (!e[o]) begin m_turn = o + 1; m_cred = wt(wv[o]); end
          else if (!e[x]) m_cred = wt(wv[x]);
          else m_turn = 0;
        end
      end
    end
    chk("VC0_pop", 32'(VC0_pop), 32'(pp[0]));
    chk("VC1_pop", 32'(VC1_pop), 32'(pp[1]));
    if (VC0_pop) begin pop_log.push_back(0); pop_cyc.push_back(cyc); end
    if (VC1_pop) begin pop_log.push_back(1); pop_cyc.push_back(cyc); end

    if (!reset_L) begin
      m_turn = 0; m_cred = 0; pushq.delete();
      m_d0 = '0; m_d1 = '0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (pp[0]) begin
      pw = q0.pop_front();
      pushq.push_back('{cyc + 2, pw, 1'b0});
    end else if (pp[1]) begin
      pw = q1.pop_front();
      pushq.push_back('{cyc + 2, pw, 1'b1});
    end
    @(posedge clk);
    #1;
    if (pp[0]) VC0_data = pw;
    if (pp[1]) VC1_data = pw;
    cyc++;
  endtask

  task automatic drain(input int maxc);
    int n;
    bit done;
    n = 0;
    enable = 1'b1;
    almost_full_D0 = 1'b0;
    almost_full_D1 = 1'b0;
    done = 1'b0;
    while (!done && n < maxc) begin
      tick();
      n++;
      done = (q0.size() == 0) && (q1.size() == 0) && (pushq.size() == 0) && (m_turn == 0) && idle;
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic do_reset(input int n);
    reset_L = 1'b0;
    for (int i = 0; i < n; i++) tick();
    reset_L = 1'b1;
  endtask

  initial begin
    vec_t tbl[6];
    int   exp_order[12];
    int   n, n0, pushes, lat;
    bit   seen;

    checks = 0; errors = 0; cyc = 0;
    m_turn = 0; m_cred = 0; m_cnt0 = 0; m_cnt1 = 0; m_d0 = '0; m_d1 = '0;
    last_push_cyc = 0;
    reset_L = 1'b0; enable = 1'b0;
    almost_full_D0 = 1'b0; almost_full_D1 = 1'b0;
    weight_VC0 = 3'd1; weight_VC1 = 3'd1;
    VC0_data = '0; VC1_data = '0;
    VC0_empty = 1'b1; VC1_empty = 1'b1;

    do_reset(2);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_D0_data", 32'(D0_data), 32'd0);
    chk("rst_D1_data", 32'(D1_data), 32'd0);
    enable = 1'b1;
    tick();

    // Routing table: single words from idle, latency counted from enqueue cycle.
    tbl[0] = '{1'b0, 6'h10, 1'b0, 1'b1, 3};
    tbl[1] = '{1'b0, 6'h00, 1'b1, 1'b0, 3};
    tbl[2] = '{1'b1, 6'h3F, 1'b0, 1'b1, 3};
    tbl[3] = '{1'b1, 6'h0F, 1'b1, 1'b0, 3};
    tbl[4] = '{1'b0, 6'h2A, 1'b1, 1'b0, 3};
    tbl[5] = '{1'b1, 6'h35, 1'b0, 1'b1, 3};
    for (int i = 0; i < 6; i++) begin
      int start;
      if (tbl[i].src) q1.push_back(tbl[i].w);
      else q0.push_back(tbl[i].w);
      start = cyc;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 10) begin
        tick();
        n++;
        seen = obs_p0 || obs_p1;
      end
      lat = last_push_cyc - start;
      chk("route_seen", 32'(seen), 32'd1);
      chk("route_p0", 32'(obs_p0), 32'(tbl[i].exp_p0));
      chk("route_p1", 32'(obs_p1), 32'(tbl[i].exp_p1));
      chk("route_data", 32'(tbl[i].exp_p1 ? obs_d1 : obs_d0), 32'(tbl[i].w));
      chk("route_lat", 32'(lat), 32'(tbl[i].exp_lat));
      drain(20);
    end

    // Weights 2/1 with both VCs loaded: fixed interleave, no bubbles.
    exp_order = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    weight_VC0 = 3'd2; weight_VC1 = 3'd1;
    pop_log.delete(); pop_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(DW'($urandom));
      q1.push_back(DW'($urandom));
    end
    n = 0;
    while (pop_log.size() < 12 && n < 40) begin tick(); n++; end
    chk("wrr_npops", 32'(pop_log.size()), 32'd12);
    if (pop_log.size() >= 12) begin
      for (int i = 0; i < 12; i++) chk("wrr_order", 32'(pop_log[i]), 32'(exp_order[i]));
      chk("wrr_nobubble", 32'(pop_cyc[11] - pop_cyc[0]), 32'd11);
    end
    drain(20);

    // VC1 empty, weight 3, 5 words: credit reloads back-to-back.
    weight_VC0 = 3'd3;
    pop_log.delete(); pop_cyc.delete();
    for (int i = 0; i < 5; i++) q0.push_back(DW'($urandom));
    n = 0;
    while (pop_log.size() < 5 && n < 20) begin tick(); n++; end
    chk("solo_npops", 32'(pop_log.size()), 32'd5);
    if (pop_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("solo_src", 32'(pop_log[i]), 32'd0);
      chk("solo_nobubble", 32'(pop_cyc[4] - pop_cyc[0]), 32'd4);
    end
    drain(20);

    // Back-pressure mid-turn: stall, trailing pushes, resume on held credit.
    weight_VC0 = 3'd3; weight_VC1 = 3'd3;
    pop_log.delete(); pop_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(DW'($urandom));
      q1.push_back(DW'($urandom));
    end
    n = 0;
    while (pop_log.size() < 2 && n < 20) begin tick(); n++; end
    chk("af_prefill", 32'(pop_log.size()), 32'd2);
    almost_full_D1 = 1'b1;
    n0 = pop_log.size();
    pushes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs_p0 || obs_p1) pushes++;
    end
    chk("af_nopop", 32'(pop_log.size() - n0), 32'd0);
    chk("af_trailing", 32'(pushes), 32'd2);
    almost_full_D1 = 1'b0;
    n = 0;
    while (pop_log.size() < 4 && n < 10) begin tick(); n++; end
    chk("af_resume_n", 32'(pop_log.size() >= 4), 32'd1);
    if (pop_log.size() >= 4) begin
      chk("af_held_credit", 32'(pop_log[2]), 32'd0);
      chk("af_then_vc1", 32'(pop_log[3]), 32'd1);
    end
    drain(40);

    // Reset one cycle after a pop drops the in-flight word.
    pop_log.delete();
    q0.push_back(6'h11);
    n = 0;
    while (pop_log.size() < 1 && n < 10) begin tick(); n++; end
    chk("rst_pop_seen", 32'(pop_log.size()), 32'd1);
    do_reset(1);
    pushes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (obs_p0 || obs_p1) pushes++;
    end
    chk("rst_no_push", 32'(pushes), 32'd0);
    chk("rst_idle2", 32'(idle), 32'd1);
    chk("rst_D1_data2", 32'(D1_data), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 4 && q0.size() < 12) q0.push_back(DW'($urandom));
      if ($urandom_range(0, 9) < 3 && q1.size() < 12) q1.push_back(DW'($urandom));
      almost_full_D0 = ($urandom_range(0, 9) == 0);
      almost_full_D1 = ($urandom_range(0, 9) == 0);
      enable         = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) weight_VC0 = WW'($urandom);
      if ($urandom_range(0, 31) == 0) weight_VC1 = WW'($urandom);
      reset_L = ($urandom_range(0, 199) != 0);
      tick();
      reset_L = 1'b1;
    end
    drain(100);

    // Counter saturation: 300 words from VC0 after a clean reset.
    do_reset(1);
    weight_VC0 = 3'd7;
    for (int i = 0; i < 300; i++) q0.push_back(DW'($urandom));
    drain(400);
`ifdef ARBITRO_STATS_EN
    chk("stats_vc0", 32'(count_VC0), 32'd255);
`else
    chk("stats_vc0", 32'(count_VC0), 32'd0);
`endif
    chk("stats_vc1", 32'(count_VC1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
